alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Upstream control stage for the 16-bit ALU datapath. It accepts an opcode and operands over a valid/ready handshake and decodes the opcode into the one-hot 16-bit select that drives the ALU's 16-input result mux. It then captures the mux's 32-bit result, derives status flags, and maintains a 32-bit accumulator that can be fed back as operand A. Results are returned over a second valid/ready handshake.

## Interface
Parameters:
- none; the datapath is fixed at 16-bit operands and a 32-bit result.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge.
- opcode  in  4  operation code (map below).
- operand_a  in  16  operand A.
- operand_b  in  16  operand B.
- use_acc  in  1  when 1, the effective A is acc[15:0] instead of operand_a.
- alu_sel  out  16  one-hot select to the ALU result mux.
- alu_a  out  16  registered effective A, driven to the ALU.
- alu_b  out  16  registered B, driven to the ALU.
- alu_result  in  32  output of the ALU result mux.
- out_valid  out  1  response valid.
- out_ready  in  1  response consumed when out_valid & out_ready at a clk edge.
- result  out  32  response data.
- overflow  out  1  overflow/borrow flag for the response.
- div_zero  out  1  divide-by-zero flag for the response.
- illegal  out  1  illegal-opcode flag for the response.
- acc  out  32  accumulator.
- sticky_err  out  1  set by any div_zero or illegal response; cleared only by CLR or rst.

## Operation
Opcode map:
- 0 NOP
- 1 ADD
- 2 SUB
- 3 MULT
- 4 DIV
- 5 SLL
- 6 SRL
- 7 AND
- 8 OR
- 9 XOR
- 10 NOT
- 11 NAND
- 12 NOR
- 13 CLR
- 14 LOAD
- 15 illegal

Select decode: for opcodes 1–12, alu_sel = 1 << opcode. Otherwise alu_sel = 0. Mux input a0 is unused.

State machine (IDLE, EXEC, RESP):
- IDLE: in_ready=1. On handshake, register opcode, alu_a = use_acc ? acc[15:0] : operand_a, and alu_b = operand_b. Go to EXEC.
- EXEC: alu_sel is driven from the registered opcode (zero in all other states). At the next edge, capture the result and flags and update acc/sticky_err. Go to RESP.
- RESP: out_valid=1. result and flags are held stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Requests and responses never overlap.

Result and flag rules (evaluated at the EXEC edge):
- Ops 1–12, except DIV with B=0: result = alu_result unmodified. acc ← result.
- ADD: overflow = alu_result[16].
- SUB: overflow = (alu_a < alu_b), the borrow. The result wraps to 32 bits.
- MULT, SLL: overflow = (alu_result[31:16] != 0).
- All other ops: overflow = 0.
- DIV with alu_b == 0: result = 32'hFFFF_FFFF, div_zero=1. acc is unchanged; alu_result is ignored.
- NOP: result = acc. acc is unchanged. All flags 0.
- CLR: acc ← 0, result = 0, sticky_err ← 0.
- LOAD: acc ← {16'h0, alu_a}. result equals the new acc.
- Opcode 15: result = 0, illegal=1. acc is unchanged.
- sticky_err ← sticky_err | div_zero | illegal. CLR clears it, and CLR takes priority.

## Timing
- Reset, for every cycle rst is sampled high:
  - state → IDLE.
  - in_ready, out_valid, alu_sel, alu_a, alu_b, result, overflow, div_zero, illegal, acc, sticky_err all 0.
  - in_ready is gated low while rst=1 and rises in the first cycle after rst deasserts.
- Latency:
  - Request handshake at edge E0 → EXEC during cycle E0..E1.
  - out_valid is high from E1. The minimum is 2 cycles from acceptance to out_valid.
  - With out_ready held high, the response handshake occurs at E2, and in_ready is high again in the cycle after E2.
  - Maximum throughput is one operation per 3 cycles.
- ALU timing: alu_result is combinational from alu_sel/alu_a/alu_b and must settle within the single EXEC cycle.
- Backpressure: while in RESP with out_ready=0, result, flags, and acc hold indefinitely, and in_ready=0.
- Reset mid-operation: rst in EXEC or RESP abandons the operation with no response. All outputs return to reset values at that edge.
- use_acc samples acc at the acceptance edge, which always reflects the previous completed operation.

## Test plan
- ADD with A=50000, B=50000 → result=32'h0001_86A0, overflow=1, acc=32'h0001_86A0, out_valid exactly 2 cycles after acceptance.
- LOAD with A=7; MULT use_acc, B=6 → result=42; SUB use_acc, B=50 → result=32'hFFFF_FFF8, overflow=1; acc tracks the result each step.
- DIV with A=100, B=0 → result=32'hFFFF_FFFF, div_zero=1, acc unchanged, sticky_err=1. A following CLR → acc=0, sticky_err=0.
- Opcode 15 → alu_sel stays 0 in EXEC, result=0, illegal=1, sticky_err=1. Opcode 7 with A=16'hF0F0, B=16'h0FF0 → alu_sel=16'h0080, result=32'h0000_00F0.
- Backpressure: hold out_ready=0 for 5 cycles while pulsing in_valid → out_valid and result stay stable, in_ready=0, no extra request is accepted; response completes when out_ready=1.
- Assert rst for one cycle during EXEC → next cycle out_valid=0, acc=0, sticky_err=0, alu_sel=0; in_ready=1 in the following cycle, and a fresh ADD 1+2 → result=3.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Request/ALU/response bundle between the upstream issuer, the ALU and the
// sequencer. The sequencer takes the slave side.
interface alu_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        use_acc;
  logic [15:0] alu_sel;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        div_zero;
  logic        illegal;
  logic [31:0] acc;
  logic        sticky_err;

  modport master (
    output in_valid, opcode, operand_a, operand_b, use_acc, alu_result, out_ready,
    input  in_ready, alu_sel, alu_a, alu_b, out_valid, result, overflow, div_zero,
           illegal, acc, sticky_err
  );

  modport slave (
    input  in_valid, opcode, operand_a, operand_b, use_acc, alu_result, out_ready,
    output in_ready, alu_sel, alu_a, alu_b, out_valid, result, overflow, div_zero,
           illegal, acc, sticky_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU control stage: decodes an opcode into a one-hot mux select, captures
// the ALU result with status flags and maintains a feedback accumulator.
module alu_op_sequencer (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [31:0] result;
    logic        overflow;
    logic        div_zero;
    logic        illegal;
  } resp_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MULT = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_CLR  = 4'd13;
  localparam logic [3:0] OP_LOAD = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  resp_t       resp_q, resp_nxt;
  logic [31:0] acc_q, acc_nxt;
  logic        sticky_q, sticky_nxt;
  logic        req_fire;

  assign req_fire = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is masked by rst so nothing is accepted during a reset cycle
  always_comb begin
    bus.in_ready  = (state == IDLE) & ~rst;
    bus.out_valid = (state == RESP);
    bus.alu_sel   = '0;
    if (state == EXEC && op_q >= OP_ADD && op_q <= OP_NOR)
      bus.alu_sel = 16'h1 << op_q;
  end

  always_comb begin
    resp_nxt = '0;
    acc_nxt  = acc_q;
    case (op_q)
      OP_NOP:  resp_nxt.result = acc_q;
      OP_CLR:  acc_nxt = '0;
      OP_LOAD: begin
        acc_nxt         = {16'h0, a_q};
        resp_nxt.result = {16'h0, a_q};
      end
      OP_ILL:  resp_nxt.illegal = 1'b1;
      OP_DIV: begin
        // a zero divisor bypasses the ALU and leaves acc untouched
        if (b_q == 16'h0) begin
          resp_nxt.result   = 32'hFFFF_FFFF;
          resp_nxt.div_zero = 1'b1;
        end else begin
          resp_nxt.result = bus.alu_result;
          acc_nxt         = bus.alu_result;
        end
      end
      default: begin
        resp_nxt.result = bus.alu_result;
        acc_nxt         = bus.alu_result;
      end
    endcase

    case (op_q)
      OP_ADD:          resp_nxt.overflow = bus.alu_result[16];
      OP_SUB:          resp_nxt.overflow = (a_q < b_q);
      OP_MULT, OP_SLL: resp_nxt.overflow = |bus.alu_result[31:16];
      default:         resp_nxt.overflow = 1'b0;
    endcase

    sticky_nxt = (op_q == OP_CLR) ? 1'b0 : (sticky_q | resp_nxt.div_zero | resp_nxt.illegal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      resp_q   <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (req_fire) begin
        op_q <= bus.opcode;
        a_q  <= bus.use_acc ? acc_q[15:0] : bus.operand_a;
        b_q  <= bus.operand_b;
      end
      if (state == EXEC) begin
        resp_q   <= resp_nxt;
        acc_q    <= acc_nxt;
        sticky_q <= sticky_nxt;
      end
    end
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.result     = resp_q.result;
  assign bus.overflow   = resp_q.overflow;
  assign bus.div_zero   = resp_q.div_zero;
  assign bus.illegal    = resp_q.illegal;
  assign bus.acc        = acc_q;
  assign bus.sticky_err = sticky_q;
endmodule
